// File: rtl/btn_cursor_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_cursor_ctrl: debounced buttons + hold-to-repeat -> per-frame cursor pos |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module btn_cursor_ctrl #(
    parameter int H_MAX    = 640,
    parameter int V_MAX    = 480,
    parameter int SIZE     = 16,
    parameter int STEP     = 4,
    parameter int HOLD_CYC = 25_000_000,
    parameter int RPT_CYC  = 5_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       up_tick,
    input  logic       down_tick,
    input  logic       left_tick,
    input  logic       right_tick,
    input  logic       up_level,
    input  logic       down_level,
    input  logic       left_level,
    input  logic       right_level,
    input  logic       frame_tick,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       moved
);

    localparam logic [1:0]         c_idle      = 2'd0;
    localparam logic [1:0]         c_delay     = 2'd1;
    localparam logic [1:0]         c_repeat    = 2'd2;
    localparam logic [25:0]        c_hold_load = 26'(HOLD_CYC - 1);
    localparam logic [25:0]        c_rpt_load  = 26'(RPT_CYC - 1);
    localparam logic signed [11:0] c_x_max     = 12'(H_MAX - SIZE);
    localparam logic signed [11:0] c_y_max     = 12'(V_MAX - SIZE);
    localparam logic signed [11:0] c_step      = 12'(STEP);
    localparam logic [9:0]         c_x_rst     = 10'((H_MAX - SIZE) / 2);
    localparam logic [9:0]         c_y_rst     = 10'((V_MAX - SIZE) / 2);

    logic [1:0]         r_state, w_state_nxt;
    logic [25:0]        r_cnt, w_cnt_nxt;
    logic               w_rpt;
    logic signed [3:0]  r_dx, r_dy;
    logic [9:0]         r_x, r_y;
    logic               r_moved;
    logic               w_any_tick, w_any_level;
    logic               w_req_up, w_req_down, w_req_left, w_req_right;
    logic signed [4:0]  w_cx, w_cy;
    logic signed [11:0] w_x_sum, w_y_sum;
    logic [9:0]         w_x_new, w_y_new;

    function automatic logic signed [3:0] sat_add(input logic signed [3:0] a,
                                                  input logic signed [4:0] b);
        logic signed [4:0] s;
        s = {a[3], a} + b;
        if (s > 5'sd7)       return 4'sd7;
        else if (s < -5'sd7) return -4'sd7;
        else                 return s[3:0];
    endfunction

    function automatic logic [9:0] clamp(input logic signed [11:0] v,
                                         input logic signed [11:0] hi);
        if (v < 12'sd0)  return '0;
        else if (v > hi) return hi[9:0];
        else             return v[9:0];
    endfunction

    assign w_any_tick  = up_tick | down_tick | left_tick | right_tick;
    assign w_any_level = up_level | down_level | left_level | right_level;

    // One repeat timer shared by all buttons; later ticks do not restart it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rpt       = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_any_tick) begin
                    w_state_nxt = c_delay;
                    w_cnt_nxt   = c_hold_load;
                end
            end
            c_delay, c_repeat: begin
                if (!w_any_level) begin
                    w_state_nxt = c_idle;
                end else if (r_cnt == '0) begin
                    w_rpt       = 1'b1;
                    w_state_nxt = c_repeat;
                    w_cnt_nxt   = c_rpt_load;
                end else begin
                    w_cnt_nxt   = r_cnt - 26'd1;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    assign w_req_up    = up_tick    | (w_rpt & up_level);
    assign w_req_down  = down_tick  | (w_rpt & down_level);
    assign w_req_left  = left_tick  | (w_rpt & left_level);
    assign w_req_right = right_tick | (w_rpt & right_level);

    assign w_cx = (w_req_right ? 5'sd1 : 5'sd0) - (w_req_left ? 5'sd1 : 5'sd0);
    assign w_cy = (w_req_down  ? 5'sd1 : 5'sd0) - (w_req_up   ? 5'sd1 : 5'sd0);

    // 12-bit signed keeps negative and oversized sums intact for clamping.
    assign w_x_sum = $signed({2'b00, r_x}) + ($signed({{8{r_dx[3]}}, r_dx}) * c_step);
    assign w_y_sum = $signed({2'b00, r_y}) + ($signed({{8{r_dy[3]}}, r_dy}) * c_step);
    assign w_x_new = clamp(w_x_sum, c_x_max);
    assign w_y_new = clamp(w_y_sum, c_y_max);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_idle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x     <= c_x_rst;
            r_y     <= c_y_rst;
            r_dx    <= '0;
            r_dy    <= '0;
            r_moved <= 1'b0;
        end else if (frame_tick) begin
            r_x     <= w_x_new;
            r_y     <= w_y_new;
            r_moved <= (w_x_new != r_x) || (w_y_new != r_y);
            // Requests arriving with the frame start the next accumulation.
            r_dx    <= w_cx[3:0];
            r_dy    <= w_cy[3:0];
        end else begin
            r_moved <= 1'b0;
            r_dx    <= sat_add(r_dx, w_cx);
            r_dy    <= sat_add(r_dy, w_cy);
        end
    end

    assign x_pos = r_x;
    assign y_pos = r_y;
    assign moved = r_moved;

endmodule
`default_nettype wire

// File: tb/tb_btn_cursor_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_btn_cursor_ctrl: directed + randomized bench with behavioural model     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_btn_cursor_ctrl;

    localparam int c_hold = 10;
    localparam int c_rpt  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       up_tick = 0, down_tick = 0, left_tick = 0, right_tick = 0;
    logic       up_level = 0, down_level = 0, left_level = 0, right_level = 0;
    logic       frame_tick = 0;
    logic [9:0] x_pos, y_pos;
    logic       moved;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_x, m_y, m_dx, m_dy, m_moved;
    bit m_active;
    int m_t0;
    int cyc = 0;

    btn_cursor_ctrl #(
        .H_MAX(640), .V_MAX(480), .SIZE(16), .STEP(4),
        .HOLD_CYC(c_hold), .RPT_CYC(c_rpt)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .up_tick(up_tick), .down_tick(down_tick),
        .left_tick(left_tick), .right_tick(right_tick),
        .up_level(up_level), .down_level(down_level),
        .left_level(left_level), .right_level(right_level),
        .frame_tick(frame_tick),
        .x_pos(x_pos), .y_pos(y_pos), .moved(moved)
    );

    always #5 clk = ~clk;

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : ((v < -7) ? -7 : v);
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_x = 312; m_y = 232; m_dx = 0; m_dy = 0; m_moved = 0; m_active = 0; m_t0 = 0;
    endtask

    // Repeats fall at HOLD after the initiating tick, then every RPT, while any level is held.
    task automatic model_step();
        bit any_tick, any_level, rpt;
        int age, cx, cy, nx, ny;
        any_tick  = up_tick | down_tick | left_tick | right_tick;
        any_level = up_level | down_level | left_level | right_level;
        rpt = 0;
        if (m_active) begin
            if (!any_level) m_active = 0;
            else begin
                age = cyc - m_t0;
                if (age >= c_hold && ((age - c_hold) % c_rpt) == 0) rpt = 1;
            end
        end else if (any_tick) begin
            m_active = 1;
            m_t0 = cyc;
        end
        cx = int'(right_tick | (rpt & right_level)) - int'(left_tick | (rpt & left_level));
        cy = int'(down_tick | (rpt & down_level)) - int'(up_tick | (rpt & up_level));
        if (frame_tick) begin
            nx = clampi(m_x + m_dx * 4, 624);
            ny = clampi(m_y + m_dy * 4, 464);
            m_moved = (nx != m_x || ny != m_y) ? 1 : 0;
            m_x = nx; m_y = ny; m_dx = cx; m_dy = cy;
        end else begin
            m_moved = 0;
            m_dx = sat7(m_dx + cx);
            m_dy = sat7(m_dy + cy);
        end
    endtask

    task automatic clk_step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        up_tick = 0; down_tick = 0; left_tick = 0; right_tick = 0; frame_tick = 0;
    endtask

    task automatic do_reset();
        up_tick = 0; down_tick = 0; left_tick = 0; right_tick = 0; frame_tick = 0;
        up_level = 0; down_level = 0; left_level = 0; right_level = 0;
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (x_pos !== 10'd312) begin errors++; $display("FAIL reset_x got %0d want 312", x_pos); end
        checks++; if (y_pos !== 10'd232) begin errors++; $display("FAIL reset_y got %0d want 232", y_pos); end
        checks++; if (moved !== 1'b0) begin errors++; $display("FAIL reset_moved got %0b want 0", moved); end
        reset_n = 1;
        frame_tick = 1; clk_step();
        checks++; if (x_pos !== 10'd312 || y_pos !== 10'd232) begin errors++; $display("FAIL idle_frame_pos got %0d,%0d want 312,232", x_pos, y_pos); end
        checks++; if (moved !== 1'b0) begin errors++; $display("FAIL idle_frame_moved got %0b want 0", moved); end
    endtask

    task automatic test_single_move();
        do_reset(); reset_n = 1;
        right_tick = 1; clk_step();
        repeat (4) clk_step();
        frame_tick = 1; clk_step();
        checks++; if (x_pos !== 10'd316) begin errors++; $display("FAIL single_right_x got %0d want 316", x_pos); end
        checks++; if (moved !== 1'b1) begin errors++; $display("FAIL single_moved_hi got %0b want 1", moved); end
        clk_step();
        checks++; if (moved !== 1'b0) begin errors++; $display("FAIL single_moved_lo got %0b want 0", moved); end
        up_tick = 1; clk_step();
        frame_tick = 1; clk_step();
        checks++; if (y_pos !== 10'd228) begin errors++; $display("FAIL single_up_y got %0d want 228", y_pos); end
    endtask

    task automatic test_cancel_saturate();
        do_reset(); reset_n = 1;
        left_tick = 1; right_tick = 1; clk_step();
        frame_tick = 1; clk_step();
        checks++; if (x_pos !== 10'd312) begin errors++; $display("FAIL cancel_x got %0d want 312", x_pos); end
        checks++; if (moved !== 1'b0) begin errors++; $display("FAIL cancel_moved got %0b want 0", moved); end
        repeat (9) begin right_tick = 1; clk_step(); end
        frame_tick = 1; clk_step();
        checks++; if (x_pos !== 10'd340) begin errors++; $display("FAIL saturate_x got %0d want 340", x_pos); end
    endtask

    task automatic test_clamp();
        do_reset(); reset_n = 1;
        repeat (12) begin
            repeat (7) begin right_tick = 1; clk_step(); end
            frame_tick = 1; clk_step();
        end
        checks++; if (x_pos !== 10'd624) begin errors++; $display("FAIL clamp_x_max got %0d want 624", x_pos); end
        right_tick = 1; clk_step();
        frame_tick = 1; clk_step();
        checks++; if (x_pos !== 10'd624 || moved !== 1'b0) begin errors++; $display("FAIL clamp_x_hold got x=%0d moved=%0b want 624,0", x_pos, moved); end
        repeat (10) begin
            repeat (7) begin up_tick = 1; clk_step(); end
            frame_tick = 1; clk_step();
        end
        checks++; if (y_pos !== 10'd0) begin errors++; $display("FAIL clamp_y_min got %0d want 0", y_pos); end
        up_tick = 1; clk_step();
        frame_tick = 1; clk_step();
        checks++; if (y_pos !== 10'd0 || moved !== 1'b0) begin errors++; $display("FAIL clamp_y_hold got y=%0d moved=%0b want 0,0", y_pos, moved); end
    endtask

    task automatic test_auto_repeat();
        do_reset(); reset_n = 1;
        up_tick = 1; up_level = 1; clk_step();
        repeat (29) clk_step();
        up_level = 0; frame_tick = 1; clk_step();
        checks++; if (y_pos !== 10'd208) begin errors++; $display("FAIL repeat_y got %0d want 208", y_pos); end
        repeat (12) clk_step();
        frame_tick = 1; clk_step();
        checks++; if (y_pos !== 10'd208 || moved !== 1'b0) begin errors++; $display("FAIL repeat_stop got y=%0d moved=%0b want 208,0", y_pos, moved); end
    endtask

    task automatic test_back_to_back();
        do_reset(); reset_n = 1;
        right_tick = 1; clk_step();
        right_tick = 1; clk_step();
        right_tick = 1; frame_tick = 1; clk_step();
        checks++; if (x_pos !== 10'd320) begin errors++; $display("FAIL collide_first got %0d want 320", x_pos); end
        frame_tick = 1; clk_step();
        checks++; if (x_pos !== 10'd324 || moved !== 1'b1) begin errors++; $display("FAIL collide_second got x=%0d moved=%0b want 324,1", x_pos, moved); end
        frame_tick = 1; clk_step();
        checks++; if (x_pos !== 10'd324 || moved !== 1'b0) begin errors++; $display("FAIL b2b_empty got x=%0d moved=%0b want 324,0", x_pos, moved); end
    endtask

    task automatic test_reset_mid();
        do_reset(); reset_n = 1;
        repeat (3) begin right_tick = 1; clk_step(); end
        #2 reset_n = 0;
        #1;
        checks++; if (x_pos !== 10'd312 || moved !== 1'b0) begin errors++; $display("FAIL async_reset got x=%0d moved=%0b want 312,0", x_pos, moved); end
        @(posedge clk); #1;
        model_reset();
        reset_n = 1;
        frame_tick = 1; clk_step();
        checks++; if (x_pos !== 10'd312 || moved !== 1'b0) begin errors++; $display("FAIL reset_discard got x=%0d moved=%0b want 312,0", x_pos, moved); end
    endtask

    task automatic test_random();
        logic [3:0] lv;
        int k;
        do_reset(); reset_n = 1;
        lv = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                k = $urandom_range(0, 3);
                lv[k] = ~lv[k];
                if (lv[k]) begin
                    case (k)
                        0: up_tick = 1;
                        1: down_tick = 1;
                        2: left_tick = 1;
                        default: right_tick = 1;
                    endcase
                end
            end
            if ($urandom_range(0, 39) == 0) right_tick = 1;
            if ($urandom_range(0, 39) == 0) up_tick = 1;
            up_level = lv[0]; down_level = lv[1]; left_level = lv[2]; right_level = lv[3];
            frame_tick = ($urandom_range(0, 11) == 0);
            clk_step();
            checks++;
            if (int'(x_pos) != m_x || int'(y_pos) != m_y || int'(moved) != m_moved) begin
                errors++;
                $display("FAIL random_cyc%0d got x=%0d y=%0d m=%0b want x=%0d y=%0d m=%0d",
                         i, x_pos, y_pos, moved, m_x, m_y, m_moved);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_move();
        test_cancel_saturate();
        test_clamp();
        test_auto_repeat();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_cursor_ctrl.md
# btn_cursor_ctrl

Converts debounced push-button events into a cursor position for the VGA display. It consumes the per-button `db_tick`/`db_level` pairs from the debouncers and adds hold-to-repeat. It accumulates moves between frames and commits a clamped (x, y) square position once per frame, so the pixel generator never sees a mid-frame change.

## Interface
- `H_MAX`, 640: visible width in pixels.
- `V_MAX`, 480: visible height in pixels.
- `SIZE`, 16: cursor square edge in pixels.
- `STEP`, 4: pixels moved per request.
- `HOLD_CYC`, 25_000_000: cycles from the initial tick to the first auto-repeat.
- `RPT_CYC`, 5_000_000: cycles between subsequent auto-repeats.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `up_tick`, `down_tick`, `left_tick`, `right_tick` in 1 each: one-cycle debounced press pulses.
- `up_level`, `down_level`, `left_level`, `right_level` in 1 each: debounced held levels.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blanking.
- `x_pos` out 10: committed left edge of the cursor.
- `y_pos` out 10: committed top edge of the cursor.
- `moved` out 1: one-cycle pulse when the committed position changes.

## Operation
- Repeat FSM, shared by all buttons. It has a 26-bit down-counter `cnt`.
  - IDLE: any `*_tick` moves to DELAY and loads `cnt = HOLD_CYC-1`.
  - DELAY:
    - If no `*_level` is high, go to IDLE.
    - Else if `cnt == 0`, assert `rpt`, go to REPEAT and load `cnt = RPT_CYC-1`.
    - Else decrement `cnt`.
  - REPEAT:
    - If no `*_level` is high, go to IDLE.
    - Else if `cnt == 0`, assert `rpt` and reload `RPT_CYC-1`.
    - Else decrement `cnt`.
  - A new `*_tick` while in DELAY or REPEAT does not restart the counter.
- Requests: `req_d = d_tick | (rpt & d_level)` for each direction d.
- Pending deltas `dx` and `dy` are 4-bit signed and count steps.
  - `dx` gains +1 for `req_right` and -1 for `req_left`. Both in the same cycle cancel.
  - `dy` gains +1 for `req_down` and -1 for `req_up`.
  - Both saturate at +7 and -7.
- Commit on `frame_tick`:
  - `x_new = clamp(x_pos + dx*STEP, 0, H_MAX-SIZE)`.
  - `y_new = clamp(y_pos + dy*STEP, 0, V_MAX-SIZE)`.
  - Compute in 12-bit signed; no wrap-around is permitted.
  - `dx` and `dy` are then replaced by that same cycle's request contribution (0 or ±1), so no request is lost or double-counted.
- `moved` = 1 in the cycle after commit if `x_new != x_pos` or `y_new != y_pos`. A clamped, no-change commit gives `moved` = 0.
- Reset values:
  - `x_pos = (H_MAX-SIZE)/2 = 312`, `y_pos = (V_MAX-SIZE)/2 = 232`.
  - `moved = 0`, `dx = dy = 0`, FSM = IDLE, `cnt = 0`.
- Reset mid-operation discards pending deltas and repeat state immediately (asynchronous).

## Timing
- A request in cycle n is reflected in `dx`/`dy` from cycle n+1.
- `frame_tick` sampled at edge f: `x_pos`/`y_pos` are new from edge f, and `moved` is high for exactly the cycle after edge f.
- First `rpt` occurs exactly `HOLD_CYC` cycles after the initiating tick. Later ones come every `RPT_CYC` cycles while any level stays high.
- A level dropping in cycle n returns the FSM to IDLE at edge n+1, with no trailing `rpt`.
- `frame_tick` in two consecutive cycles gives two commits; the second uses only requests from the first cycle.
- Outputs are registered, with no combinational path from inputs.

## Test plan
- Reset: hold `reset_n` = 0 -> `x_pos` = 312, `y_pos` = 232, `moved` = 0. Release, then `frame_tick` with no input -> no change, `moved` = 0.
- Single move: `right_tick`, then `frame_tick` 5 cycles later -> `x_pos` = 316, `moved` high for one cycle. `up_tick`, then frame -> `y_pos` = 228.
- Cancel and saturate:
  - `left_tick` and `right_tick` in the same cycle, then frame -> `x_pos` unchanged, `moved` = 0.
  - 9 `right_tick`s, then frame -> `x_pos` = 312 + 28 = 340.
- Clamp: repeated `right_tick` + frame until `x_pos` = 624. Another `right_tick` + frame -> `x_pos` = 624, `moved` = 0. Same check at `y_pos` = 0 using up.
- Auto-repeat with `HOLD_CYC` = 10 and `RPT_CYC` = 4:
  - `up_tick` at cycle 0 with `up_level` held through cycle 29 -> requests at cycles 0, 10, 14, 18, 22, 26.
  - Frame at cycle 30 -> `y_pos` = 232 - 24 = 208.
  - Drop `up_level` -> no further requests.
- Collision and reset:
  - `right_tick` coincident with `frame_tick` while `dx` = 2 -> x +8 now, +4 at the next frame.
  - Separately, build `dx` = 3, pulse `reset_n` low, then frame -> `x_pos` = 312.
